counter_cmd_seq: RTL and testbench

COUNTER_CMD_SEQ -- requirements
Module: counter_cmd_seq

---
 rtl/counter_cmd_seq_pkg.sv | 17 +
 rtl/counter_cmd_seq_if.sv | 17 +
 rtl/counter_cmd_seq.sv | 101 ++++++++++
 tb/tb_counter_cmd_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/counter_cmd_seq_pkg.sv
// Shared types for the counter command sequencer: the command opcodes
// and the two FSM states.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_UP    = 2'd1,
        OP_DOWN  = 2'd2,
        OP_PAUSE = 2'd3
    } op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/counter_cmd_seq_if.sv
// Command channel into the sequencer. It carries a valid/ready handshake
// plus the opcode, the load value and the length fields.
interface counter_cmd_seq_if
    import counter_seq_pkg::*;
#(
    parameter int W  = 4,
    parameter int LW = 8
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    op_t           cmd_op;
    logic [W-1:0]  cmd_val;
    logic [LW-1:0] cmd_len;

    modport master (output cmd_valid, cmd_op, cmd_val, cmd_len, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_val, cmd_len, output cmd_ready);
endinterface

// File: rtl/counter_cmd_seq.sv
// Turns LOAD/UP/DOWN/PAUSE commands into registered ce/load/up_down strobes
// for a downstream counter. A command offered in the final cycle runs back-to-back.
module counter_cmd_seq
    import counter_seq_pkg::*;
#(
    parameter int W  = 4,
    parameter int LW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_cmd_seq_if.slave     cmd,
    input  logic                 abort,
    output logic                 ce,
    output logic                 load,
    output logic [W-1:0]         load_val,
    output logic                 up_down,
    output logic                 busy,
    output logic                 done
);

    state_t        state, state_next;
    logic [LW-1:0] rem, rem_next;
    logic          ce_next, load_next, up_down_next, done_next;
    logic [W-1:0]  load_val_next;
    logic          last, accept;

    // A length-0 command sits at rem==0 for its single cycle, so both 0 and 1 mark the end.
    assign last           = (state == S_EXEC) && (rem <= LW'(1));
    assign cmd.cmd_ready  = ((state == S_IDLE) || last) && !abort && rst;
    assign accept         = cmd.cmd_valid && cmd.cmd_ready;
    assign busy           = (state == S_EXEC);

    always_comb begin
        state_next    = state;
        rem_next      = rem;
        ce_next       = ce;
        load_next     = load;
        load_val_next = load_val;
        up_down_next  = up_down;
        done_next     = 1'b0;

        if (state == S_EXEC) begin
            if (abort || last) begin
                done_next     = !abort;
                state_next    = S_IDLE;
                rem_next      = '0;
                ce_next       = 1'b0;
                load_next     = 1'b0;
                load_val_next = '0;
            end else begin
                rem_next = rem - LW'(1);
            end
        end

        if (accept) begin
            state_next    = S_EXEC;
            load_next     = 1'b0;
            load_val_next = '0;
            rem_next      = cmd.cmd_len;
            ce_next       = 1'b0;
            case (cmd.cmd_op)
                OP_LOAD: begin
                    rem_next      = LW'(1);
                    ce_next       = 1'b1;
                    load_next     = 1'b1;
                    load_val_next = cmd.cmd_val;
                end
                OP_UP: begin
                    ce_next      = (cmd.cmd_len != '0);
                    up_down_next = 1'b1;
                end
                OP_DOWN: begin
                    ce_next      = (cmd.cmd_len != '0);
                    up_down_next = 1'b0;
                end
                default: ce_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            rem      <= '0;
            ce       <= 1'b0;
            load     <= 1'b0;
            load_val <= '0;
            up_down  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            rem      <= rem_next;
            ce       <= ce_next;
            load     <= load_next;
            load_val <= load_val_next;
            up_down  <= up_down_next;
            done     <= done_next;
        end
    end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Directed bench for counter_cmd_seq (W=4, LW=8) with hand-computed expectations.
module tb_counter_cmd_seq;
    import counter_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       abort = 1'b0;
    logic       ce, load, up_down, busy, done;
    logic [3:0] load_val;
    int         n_cmp = 0;
    int         n_bad = 0;

    counter_cmd_seq_if #(.W(4), .LW(8)) cif ();

    counter_cmd_seq #(.W(4), .LW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cif.slave),
        .abort    (abort),
        .ce       (ce),
        .load     (load),
        .load_val (load_val),
        .up_down  (up_down),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic e_ce, input logic e_load,
                        input logic [3:0] e_val, input logic e_ud,
                        input logic e_busy, input logic e_done);
        chk({tag, ".ce"}, 32'(ce), 32'(e_ce));
        chk({tag, ".load"}, 32'(load), 32'(e_load));
        chk({tag, ".load_val"}, 32'(load_val), 32'(e_val));
        chk({tag, ".up_down"}, 32'(up_down), 32'(e_ud));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
    endtask

    task automatic offer(input op_t op, input logic [3:0] v, input logic [7:0] len);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_val   = v;
        cif.cmd_len   = len;
    endtask

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = OP_LOAD;
        cif.cmd_val   = '0;
        cif.cmd_len   = '0;

        // Reset state
        step(); step();
        outs("rst", 0, 0, 4'd0, 0, 0, 0);
        chk("rst.ready", 32'(cif.cmd_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst.ready", 32'(cif.cmd_ready), 32'd1);

        // LOAD 5
        offer(OP_LOAD, 4'd5, 8'd0);
        step();
        cif.cmd_valid = 1'b0;
        outs("load5.c1", 1, 1, 4'd5, 0, 1, 0);
        step();
        outs("load5.done", 0, 0, 4'd0, 0, 0, 1);
        step();
        chk("load5.done_clr", 32'(done), 32'd0);

        // UP 3 then DOWN 2 back-to-back
        offer(OP_UP, 4'd0, 8'd3);
        step();
        cif.cmd_valid = 1'b0;
        outs("up.c1", 1, 0, 4'd0, 1, 1, 0);
        step();
        outs("up.c2", 1, 0, 4'd0, 1, 1, 0);
        step();
        outs("up.c3", 1, 0, 4'd0, 1, 1, 0);
        offer(OP_DOWN, 4'd0, 8'd2);
        #1;
        chk("up.final_ready", 32'(cif.cmd_ready), 32'd1);
        step();
        cif.cmd_valid = 1'b0;
        outs("down.c1", 1, 0, 4'd0, 0, 1, 1);
        step();
        outs("down.c2", 1, 0, 4'd0, 0, 1, 0);
        step();
        outs("down.done", 0, 0, 4'd0, 0, 0, 1);

        // PAUSE length 0
        offer(OP_PAUSE, 4'd0, 8'd0);
        step();
        cif.cmd_valid = 1'b0;
        outs("pause0.c1", 0, 0, 4'd0, 0, 1, 0);
        step();
        outs("pause0.done", 0, 0, 4'd0, 0, 0, 1);

        // UP 10 aborted in EXEC cycle 4
        offer(OP_UP, 4'd0, 8'd10);
        step();
        cif.cmd_valid = 1'b0;
        step(); step(); step();
        outs("up10.c4", 1, 0, 4'd0, 1, 1, 0);
        abort = 1'b1;
        #1;
        chk("abort.ready", 32'(cif.cmd_ready), 32'd0);
        step();
        abort = 1'b0;
        outs("abort.after", 0, 0, 4'd0, 1, 0, 0);
        #1;
        chk("abort.ready_after", 32'(cif.cmd_ready), 32'd1);
        step();
        chk("abort.no_done", 32'(done), 32'd0);

        // LOAD must keep the previous direction
        offer(OP_LOAD, 4'd9, 8'd0);
        step();
        cif.cmd_valid = 1'b0;
        outs("load9.c1", 1, 1, 4'd9, 1, 1, 0);
        step();
        outs("load9.done", 0, 0, 4'd0, 1, 0, 1);

        // UP 200 interrupted by reset in cycle 50
        offer(OP_UP, 4'd0, 8'd200);
        step();
        cif.cmd_valid = 1'b0;
        for (int i = 0; i < 49; i++) step();
        outs("up200.c50", 1, 0, 4'd0, 1, 1, 0);
        rst = 1'b0;
        #1;
        outs("up200.rst", 0, 0, 4'd0, 0, 0, 0);
        chk("up200.rst_ready", 32'(cif.cmd_ready), 32'd0);
        step(); step();
        rst = 1'b1;
        #1;
        chk("up200.rel_ready", 32'(cif.cmd_ready), 32'd1);
        step();
        outs("up200.no_done", 0, 0, 4'd0, 0, 0, 0);
        offer(OP_LOAD, 4'd15, 8'd0);
        step();
        cif.cmd_valid = 1'b0;
        outs("load15.c1", 1, 1, 4'd15, 0, 1, 0);
        step();
        outs("load15.done", 0, 0, 4'd0, 0, 0, 1);

        // abort with cmd_valid in IDLE
        abort = 1'b1;
        offer(OP_UP, 4'd0, 8'd3);
        #1;
        chk("idle_abort.ready", 32'(cif.cmd_ready), 32'd0);
        step();
        outs("idle_abort.c1", 0, 0, 4'd0, 0, 0, 0);
        step();
        outs("idle_abort.c2", 0, 0, 4'd0, 0, 0, 0);
        abort = 1'b0;
        cif.cmd_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
